alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Command-side controller for the team's combinational 8-bit ALU (9-bit result, 4-bit select).
- Accepts operation requests over a valid/ready command channel and drives the ALU operand and select inputs from registers.
- Captures the ALU result, or computes multiply (select 0010) internally with an iterative shift-add unit.
- Returns a 16-bit result plus flags over a valid/ready response channel. It sits between a host/testbench sequencer and the ALU.

Parameters:
- DATA_W, 8, operand width; the ALU result width is DATA_W+1.
- SEL_W, 4, operation select width.
- RES_W, 16, response result width (2*DATA_W).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_sel  input  SEL_W  operation select, same encoding as the ALU.
- cmd_a  input  DATA_W  operand A.
- cmd_b  input  DATA_W  operand B.
- alu_a  output  DATA_W  registered operand A to the ALU.
- alu_b  output  DATA_W  registered operand B to the ALU.
- alu_sel  output  SEL_W  registered select to the ALU.
- alu_result  input  DATA_W+1  combinational ALU result.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  RES_W  result, zero-extended for ALU operations.
- rsp_zero  output  1  rsp_result == 0.
- rsp_carry  output  1  carry/borrow/overflow flag (rules below).
- rsp_dbz  output  1  divide by zero; rsp_result forced to 0.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0: cmd_ready=0 while rst is high, and alu_a/alu_b/alu_sel=0.
  - Multiply accumulator and counter are cleared.
  - An in-flight operation is abandoned with no response. rsp_valid is 0 at the first edge with rst high.
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, latch cmd_sel/a/b into alu_sel/alu_a/alu_b.
  - Next state:
    - sel==0010 -> MUL.
    - sel==0011 and cmd_b==0 -> RESP with rsp_dbz=1, rsp_result=0, rsp_zero=1, rsp_carry=0.
    - otherwise -> EXEC.
- EXEC (1 cycle):
  - Sample alu_result.
  - rsp_result = {7'b0, alu_result}.
  - rsp_carry = alu_result[8] only for sel 0000 (carry), 0001 (borrow), 0100 (bit shifted out); 0 for all other selects.
  - -> RESP.
- MUL (8 cycles):
  - Counter k runs 0..7.
  - Each cycle: if alu_b[k], acc += alu_a << k (16-bit accumulator, no wrap possible).
  - alu_result is ignored.
  - After k==7 -> RESP with rsp_result=acc and rsp_carry = |acc[15:8].
- RESP:
  - rsp_valid=1.
  - rsp_result and all flags are held stable until rsp_ready is high.
  - On handshake -> IDLE.
  - cmd_ready=0 in every state except IDLE.
- Latency from the command-accept edge to rsp_valid high:
  - EXEC path: 2 edges.
  - MUL path: 9 edges.
  - Divide-by-zero path: 1 edge.
- Throughput: the next command can be accepted in the IDLE cycle after the response handshake. There is no overlap.
- alu_a/alu_b/alu_sel stay at their last values in RESP and IDLE, and change only on command accept.
- rsp_zero is computed from the final rsp_result for every path.
- cmd_valid while not ready: ignored; the command is not lost on the consumer side because cmd_ready=0.
- Any cmd_* change while cmd_ready=0 has no effect.
- rsp_ready while rsp_valid=0: ignored.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_EQ, including OP_MUL=4'b0010 and OP_DIV=4'b0011;
  - the state enum/localparams for IDLE/EXEC/MUL/RESP;
  - DATA_W/RES_W defaults.
- One sub-module, alu_shift_add_mul: start/busy/done, 8-cycle shift-add, 16-bit product. The FSM stays in the top module.

Test Plan:
- Add cmd_sel=0000, a=0xF0, b=0x20 -> rsp_result=0x0110, carry=1, zero=0, dbz=0; rsp_valid exactly 2 edges after accept.
- Subtract:
  - 0x05-0x05 -> rsp_result=0x0000, zero=1, carry=0.
  - 0x03-0x05 -> rsp_result=0x01FE, carry=1.
- Multiply 0xFF*0xFF (sel 0010) -> rsp_result=0xFE01, carry=1, rsp_valid 9 edges after accept. Then 0x00*0x37 -> result 0, zero=1, carry=0.
- Divide:
  - 0x64/0x00 -> dbz=1, result 0, zero=1, rsp_valid 1 edge after accept.
  - 0x64/0x07 -> result 0x000E, dbz=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after an XOR 0xAA^0x0F response -> rsp_result stays 0x00A5 and cmd_ready stays 0; a second cmd_valid is not accepted until the handshake.
- Reset mid-multiply: assert rst during MUL k=4 -> next edge IDLE, rsp_valid=0, alu_* outputs=0. A following add 0x01+0x01 returns 0x0002 with correct latency.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcodes, FSM state type and default widths for the ALU command sequencer.
// Imported by the sequencer top and its shift-add multiplier.
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_SEL_W  = 4;
    localparam int ALU_RES_W  = 2 * ALU_DATA_W;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_EQ  = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_RESP
    } state_e;

    // Only add, subtract and shift-left report bit DATA_W of the ALU result.
    function automatic logic op_has_carry(input logic [3:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB) || (sel == OP_SHL);
    endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles.
// Operands must be stable while busy; product_o is valid in the done cycle.
module alu_shift_add_mul #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [2*DATA_W-1:0] product_o
);

    localparam int CNT_W = $clog2(DATA_W);

    logic                busy_q;
    logic [CNT_W-1:0]    k_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] term;
    logic [2*DATA_W-1:0] acc_d;

    assign a_ext = {{DATA_W{1'b0}}, a_i};
    assign term  = b_i[k_q] ? (a_ext << k_q) : '0;
    assign acc_d = acc_q + term;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            k_q    <= '0;
            acc_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            k_q    <= '0;
            acc_q  <= '0;
        end else if (busy_q) begin
            acc_q <= acc_d;
            k_q   <= k_q + 1'b1;
            if (k_q == CNT_W'(DATA_W - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (k_q == CNT_W'(DATA_W - 1));
    assign product_o = acc_d;

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side controller for the 8-bit combinational ALU: registers operands,
// collects the result (or multiplies internally) and returns it with flags.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int SEL_W  = ALU_SEL_W,
    parameter int RES_W  = ALU_RES_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W:0]   alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              rsp_dbz
);

    state_e              state_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic [SEL_W-1:0]    alu_sel_q;
    logic                rsp_valid_q;
    logic [RES_W-1:0]    rsp_result_q;
    logic                rsp_zero_q;
    logic                rsp_carry_q;
    logic                rsp_dbz_q;

    logic                accept;
    logic                mul_start;
    logic                mul_busy;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign mul_start = accept && (cmd_sel == OP_MUL);

    alu_shift_add_mul #(
        .DATA_W(DATA_W)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mul_start),
        .a_i      (alu_a_q),
        .b_i      (alu_b_q),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_dbz_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        alu_a_q   <= cmd_a;
                        alu_b_q   <= cmd_b;
                        alu_sel_q <= cmd_sel;
                        if (cmd_sel == OP_MUL) begin
                            state_q <= S_MUL;
                        end else if (cmd_sel == OP_DIV && cmd_b == '0) begin
                            // Divide by zero never reaches the ALU result path.
                            state_q      <= S_RESP;
                            rsp_valid_q  <= 1'b1;
                            rsp_result_q <= '0;
                            rsp_zero_q   <= 1'b1;
                            rsp_carry_q  <= 1'b0;
                            rsp_dbz_q    <= 1'b1;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    state_q      <= S_RESP;
                    rsp_valid_q  <= 1'b1;
                    rsp_result_q <= RES_W'(alu_result);
                    rsp_zero_q   <= (alu_result == '0);
                    rsp_carry_q  <= op_has_carry(alu_sel_q) && alu_result[DATA_W];
                    rsp_dbz_q    <= 1'b0;
                end
                S_MUL: begin
                    if (mul_done) begin
                        state_q      <= S_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= mul_product;
                        rsp_zero_q   <= (mul_product == '0);
                        rsp_carry_q  <= |mul_product[RES_W-1:DATA_W];
                        rsp_dbz_q    <= 1'b0;
                    end else if (!mul_busy) begin
                        state_q <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_dbz    = rsp_dbz_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the ALU.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_sel;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [8:0]  alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_carry;
    logic        rsp_dbz;

    int checks;
    int failures;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry),
        .rsp_dbz   (rsp_dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU the sequencer is meant to drive.
    always_comb begin
        alu_result = '0;
        case (alu_sel)
            4'b0000: alu_result = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0001: alu_result = {1'b0, alu_a} - {1'b0, alu_b};
            4'b0011: alu_result = (alu_b == 0) ? 9'd0 : {1'b0, alu_a / alu_b};
            4'b0100: alu_result = {alu_a, 1'b0};
            4'b0101: alu_result = {2'b0, alu_a[7:1]};
            4'b0110: alu_result = {1'b0, alu_a & alu_b};
            4'b0111: alu_result = {1'b0, alu_a | alu_b};
            4'b1000: alu_result = {1'b0, alu_a ^ alu_b};
            4'b1001: alu_result = {1'b0, ~alu_a};
            4'b1010: alu_result = {8'b0, alu_a == alu_b};
            default: alu_result = 9'h1AB;
        endcase
    end

    task automatic do_cmd(input logic [3:0] sel, input logic [7:0] a,
                          input logic [7:0] b, output int lat);
        @(negedge clk);
        cmd_sel   = sel;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_hs;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got ready=%b valid=%b exp 0 0",
                     cmd_ready, rsp_valid);
        end
        checks++;
        if ({alu_a, alu_b, alu_sel} !== 20'h0 || rsp_result !== 16'h0) begin
            failures++;
            $display("FAIL reset_regs got a=%h b=%h sel=%h res=%h exp 0",
                     alu_a, alu_b, alu_sel, rsp_result);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got ready=%b exp 1", cmd_ready);
        end
    endtask

    task automatic test_add;
        int lat;
        do_cmd(4'b0000, 8'hF0, 8'h20, lat);
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL add_latency got=%0d exp=2", lat);
        end
        checks++;
        if ({rsp_result, rsp_carry, rsp_zero, rsp_dbz} !== {16'h0110, 3'b100}) begin
            failures++;
            $display("FAIL add_rsp got res=%h c=%b z=%b d=%b exp 0110 1 0 0",
                     rsp_result, rsp_carry, rsp_zero, rsp_dbz);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL add_ready_in_resp got=%b exp=0", cmd_ready);
        end
        do_hs();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_handshake got valid=%b ready=%b exp 0 1",
                     rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_sub;
        int lat;
        do_cmd(4'b0001, 8'h05, 8'h05, lat);
        checks++;
        if ({rsp_result, rsp_zero, rsp_carry} !== {16'h0000, 2'b10} || lat != 2) begin
            failures++;
            $display("FAIL sub_equal got res=%h z=%b c=%b lat=%0d exp 0000 1 0 2",
                     rsp_result, rsp_zero, rsp_carry, lat);
        end
        do_hs();
        do_cmd(4'b0001, 8'h03, 8'h05, lat);
        checks++;
        if ({rsp_result, rsp_zero, rsp_carry} !== {16'h01FE, 2'b01}) begin
            failures++;
            $display("FAIL sub_borrow got res=%h z=%b c=%b exp 01fe 0 1",
                     rsp_result, rsp_zero, rsp_carry);
        end
        do_hs();
    endtask

    task automatic test_mul;
        int lat;
        do_cmd(4'b0010, 8'hFF, 8'hFF, lat);
        checks++;
        if (lat != 9) begin
            failures++;
            $display("FAIL mul_latency got=%0d exp=9", lat);
        end
        checks++;
        if ({rsp_result, rsp_carry, rsp_zero, rsp_dbz} !== {16'hFE01, 3'b100}) begin
            failures++;
            $display("FAIL mul_ff got res=%h c=%b z=%b d=%b exp fe01 1 0 0",
                     rsp_result, rsp_carry, rsp_zero, rsp_dbz);
        end
        do_hs();
        do_cmd(4'b0010, 8'h00, 8'h37, lat);
        checks++;
        if ({rsp_result, rsp_carry, rsp_zero} !== {16'h0000, 2'b01} || lat != 9) begin
            failures++;
            $display("FAIL mul_zero got res=%h c=%b z=%b lat=%0d exp 0000 0 1 9",
                     rsp_result, rsp_carry, rsp_zero, lat);
        end
        do_hs();
        do_cmd(4'b0010, 8'h0D, 8'h0B, lat);
        checks++;
        if ({rsp_result, rsp_carry} !== {16'h008F, 1'b0}) begin
            failures++;
            $display("FAIL mul_small got res=%h c=%b exp 008f 0",
                     rsp_result, rsp_carry);
        end
        do_hs();
    endtask

    task automatic test_div;
        int lat;
        do_cmd(4'b0011, 8'h64, 8'h00, lat);
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL dbz_latency got=%0d exp=1", lat);
        end
        checks++;
        if ({rsp_result, rsp_dbz, rsp_zero, rsp_carry} !== {16'h0000, 3'b110}) begin
            failures++;
            $display("FAIL dbz_rsp got res=%h d=%b z=%b c=%b exp 0000 1 1 0",
                     rsp_result, rsp_dbz, rsp_zero, rsp_carry);
        end
        do_hs();
        do_cmd(4'b0011, 8'h64, 8'h07, lat);
        checks++;
        if ({rsp_result, rsp_dbz, rsp_zero} !== {16'h000E, 2'b00} || lat != 2) begin
            failures++;
            $display("FAIL div_ok got res=%h d=%b z=%b lat=%0d exp 000e 0 0 2",
                     rsp_result, rsp_dbz, rsp_zero, lat);
        end
        do_hs();
    endtask

    task automatic test_backpressure;
        int lat;
        int bad;
        do_cmd(4'b1000, 8'hAA, 8'h0F, lat);
        @(negedge clk);
        cmd_sel   = 4'b0000;
        cmd_a     = 8'h11;
        cmd_b     = 8'h22;
        cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (rsp_result !== 16'h00A5 || cmd_ready !== 1'b0 ||
                rsp_valid !== 1'b1 || rsp_carry !== 1'b0) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold got bad_cycles=%0d res=%h exp 0 00a5",
                     bad, rsp_result);
        end
        checks++;
        if (alu_a !== 8'hAA || alu_sel !== 4'b1000) begin
            failures++;
            $display("FAIL bp_no_accept got a=%h sel=%h exp aa 8",
                     alu_a, alu_sel);
        end
        do_hs();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checks++;
        if (alu_a !== 8'h11 || alu_b !== 8'h22) begin
            failures++;
            $display("FAIL bp_accept_after got a=%h b=%h exp 11 22",
                     alu_a, alu_b);
        end
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (rsp_result !== 16'h0033 || lat != 2) begin
            failures++;
            $display("FAIL bp_second got res=%h lat=%0d exp 0033 2",
                     rsp_result, lat);
        end
        do_hs();
    endtask

    task automatic test_reset_mid_mul;
        int lat;
        @(negedge clk);
        cmd_sel   = 4'b0010;
        cmd_a     = 8'h12;
        cmd_b     = 8'h34;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 ||
            {alu_a, alu_b, alu_sel} !== 20'h0) begin
            failures++;
            $display("FAIL mid_reset got v=%b r=%b a=%h b=%h s=%h exp 0",
                     rsp_valid, cmd_ready, alu_a, alu_b, alu_sel);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0) break;
        end
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_abandon got v=%b r=%b exp 0 1",
                     rsp_valid, cmd_ready);
        end
        do_cmd(4'b0000, 8'h01, 8'h01, lat);
        checks++;
        if (rsp_result !== 16'h0002 || lat != 2 || rsp_carry !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_add got res=%h lat=%0d c=%b exp 0002 2 0",
                     rsp_result, lat, rsp_carry);
        end
        do_hs();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_sel   = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
